// File: rtl/branch_resolver_pkg.sv
// Shared LC-3b branch-prediction types: machine word, in-flight entry layout, and a
// saturating-increment helper for the statistics counters.
package branch_resolver_pkg;

    typedef logic [15:0] lc3b_word;

    localparam int unsigned bp_hist_width = 4;

    typedef struct packed {
        lc3b_word                 pc;
        logic                     pred;
        logic [bp_hist_width-1:0] hist;
    } bp_entry_t;

    function automatic lc3b_word sat_inc(input lc3b_word v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/branch_resolver_bp_fifo.sv
// In-flight branch queue: power-of-two depth, wrapping pointers, occupancy counter.
// Clear wins over push and pop.
module bp_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 21
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees a slot, so push+pop is legal while full.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/branch_resolver.sv
// WB-side gshare companion: tracks in-flight predicted branches, checks them at WB,
// drives predictor update and a one-cycle flush/redirect, and keeps branch statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned hist_reg_width = bp_hist_width,
    parameter int unsigned depth          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      predict_taken_if,
    input  logic [hist_reg_width-1:0] branch_hist_if,
    input  lc3b_word                  pc_if,
    input  logic                      resolve,
    input  lc3b_word                  pc_wb,
    input  logic                      taken_wb,
    input  lc3b_word                  target_wb,
    output logic                      update_en,
    output logic [hist_reg_width-1:0] branch_hist_wb,
    output logic                      mispredict,
    output lc3b_word                  redirect_pc,
    output logic                      full,
    output logic                      empty,
    output logic                      seq_error,
    output lc3b_word                  br_count,
    output lc3b_word                  mispred_count
);

    localparam int unsigned EntryW = 16 + 1 + hist_reg_width;

    logic [EntryW-1:0]         wr_entry, head;
    lc3b_word                  head_pc;
    logic                      head_pred;
    logic [hist_reg_width-1:0] head_hist;
    logic                      resolve_ok, mispredict_next;

    logic     mispredict_q, seq_error_q, seq_error_d;
    lc3b_word redirect_pc_q, redirect_pc_d;
    lc3b_word br_count_q, br_count_d, mispred_count_q, mispred_count_d;

    assign wr_entry                       = {pc_if, predict_taken_if, branch_hist_if};
    assign {head_pc, head_pred, head_hist} = head;

    assign resolve_ok      = resolve & ~empty;
    assign mispredict_next = resolve_ok & (taken_wb != head_pred);
    assign update_en       = resolve_ok;
    assign branch_hist_wb  = head_hist;

    // A mispredict flushes every younger entry, including one pushed this cycle.
    bp_fifo #(
        .Depth (depth),
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push & ~mispredict_next),
        .pop_i   (resolve_ok),
        .clear_i (mispredict_next),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        seq_error_d     = seq_error_q | (resolve & (empty | (head_pc != pc_wb)));
        redirect_pc_d   = redirect_pc_q;
        br_count_d      = resolve_ok ? sat_inc(br_count_q) : br_count_q;
        mispred_count_d = mispredict_next ? sat_inc(mispred_count_q) : mispred_count_q;
        if (mispredict_next) redirect_pc_d = taken_wb ? target_wb : pc_wb + 16'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            seq_error_q     <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            mispredict_q    <= mispredict_next;
            redirect_pc_q   <= redirect_pc_d;
            seq_error_q     <= seq_error_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign seq_error     = seq_error_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed expectations for predict/resolve traffic.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        push, predict_taken_if, resolve, taken_wb;
    logic [3:0]  branch_hist_if;
    logic [15:0] pc_if, pc_wb, target_wb;
    logic        update_en, mispredict, full, empty, seq_error;
    logic [3:0]  branch_hist_wb;
    logic [15:0] redirect_pc, br_count, mispred_count;

    int total = 0;
    int bad   = 0;

    branch_resolver #(
        .hist_reg_width (4),
        .depth          (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .predict_taken_if (predict_taken_if),
        .branch_hist_if   (branch_hist_if),
        .pc_if            (pc_if),
        .resolve          (resolve),
        .pc_wb            (pc_wb),
        .taken_wb         (taken_wb),
        .target_wb        (target_wb),
        .update_en        (update_en),
        .branch_hist_wb   (branch_hist_wb),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .full             (full),
        .empty            (empty),
        .seq_error        (seq_error),
        .br_count         (br_count),
        .mispred_count    (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic pred, input logic [3:0] hist,
                         input logic [15:0] pci, input logic r, input logic [15:0] pcw,
                         input logic tk, input logic [15:0] tgt);
        push             = p;
        predict_taken_if = pred;
        branch_hist_if   = hist;
        pc_if            = pci;
        resolve          = r;
        pc_wb            = pcw;
        taken_wb         = tk;
        target_wb        = tgt;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        step();
        step();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_redirect", redirect_pc, 16'h0);
        check("rst_seq_error", seq_error, 0);
        check("rst_br_count", br_count, 0);
        check("rst_mispred_count", mispred_count, 0);
        reset = 1'b1;

        // Correct taken prediction
        drive(1'b1, 1'b1, 4'hA, 16'h1000, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        check("t1_not_empty", empty, 0);
        drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 16'h1000, 1'b1, 16'h0);
        check("t1_update_en", update_en, 1);
        check("t1_hist_wb", branch_hist_wb, 4'hA);
        step();
        idle();
        check("t1_no_mispredict", mispredict, 0);
        check("t1_br_count", br_count, 1);
        check("t1_empty", empty, 1);

        // Not-taken prediction resolves taken with younger entries behind it
        drive(1'b1, 1'b0, 4'h3, 16'h2000, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        drive(1'b1, 1'b1, 4'h5, 16'h2002, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        drive(1'b1, 1'b1, 4'h6, 16'h2004, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 16'h2000, 1'b1, 16'h2040);
        check("t2_update_en", update_en, 1);
        check("t2_hist_wb", branch_hist_wb, 4'h3);
        step();
        idle();
        check("t2_mispredict", mispredict, 1);
        check("t2_redirect", redirect_pc, 16'h2040);
        check("t2_flushed", empty, 1);
        check("t2_mispred_count", mispred_count, 1);
        check("t2_br_count", br_count, 2);
        step();
        check("t2_pulse_one_cycle", mispredict, 0);

        // Taken prediction resolves not-taken; same-cycle push is discarded
        drive(1'b1, 1'b1, 4'h1, 16'h3000, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        drive(1'b1, 1'b1, 4'h2, 16'h3004, 1'b1, 16'h3000, 1'b0, 16'h3100);
        step();
        idle();
        check("t3_mispredict", mispredict, 1);
        check("t3_redirect", redirect_pc, 16'h3002);
        check("t3_push_dropped", empty, 1);
        check("t3_mispred_count", mispred_count, 2);

        // Fill to full, then push+resolve keeps it full, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 4'(i + 1), 16'h4000 + 16'(2 * i), 1'b0, 16'h0, 1'b0, 16'h0);
            step();
        end
        idle();
        check("t4_full", full, 1);
        drive(1'b1, 1'b1, 4'h5, 16'h4008, 1'b1, 16'h4000, 1'b1, 16'h0);
        check("t4_pr_update_en", update_en, 1);
        check("t4_pr_hist", branch_hist_wb, 4'h1);
        step();
        idle();
        check("t4_still_full", full, 1);
        check("t4_no_mispredict", mispredict, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 16'h4002 + 16'(2 * i), 1'b1, 16'h0);
            check("t4_drain_hist", branch_hist_wb, 4'(i + 2));
            step();
        end
        idle();
        check("t4_drained", empty, 1);
        check("t4_br_count", br_count, 8);
        check("t4_no_seq_error", seq_error, 0);

        // Resolve on an empty queue
        drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 16'h5555, 1'b1, 16'h0);
        check("t5_no_update", update_en, 0);
        step();
        idle();
        check("t5_seq_error", seq_error, 1);
        check("t5_br_count", br_count, 8);
        check("t5_no_mispredict", mispredict, 0);

        // Reset mid-traffic, then a PC mismatch
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'h7, 16'h6000 + 16'(2 * i), 1'b0, 16'h0, 1'b0, 16'h0);
            step();
        end
        idle();
        check("t6_pre_reset_nonempty", empty, 0);
        reset = 1'b0;
        #1;
        check("t6_reset_empty", empty, 1);
        check("t6_reset_br_count", br_count, 0);
        check("t6_reset_mispred_count", mispred_count, 0);
        check("t6_reset_seq_error", seq_error, 0);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b0, 4'h6, 16'h5000, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        check("t6_push_accepted", empty, 0);
        drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 16'h5010, 1'b0, 16'h0);
        check("t6_update_en", update_en, 1);
        check("t6_hist_wb", branch_hist_wb, 4'h6);
        step();
        idle();
        check("t6_pc_mismatch_seq_error", seq_error, 1);
        check("t6_no_mispredict", mispredict, 0);
        check("t6_br_count", br_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
